// File: rtl/irq_pin_conditioner_pkg.sv
// Shared types and constants for the CPU interrupt/reset pin conditioner.
// Package name: irq_cond_pkg.
package irq_cond_pkg;

    // Width of the reset qualify/hold counter and the optional IRQ filter counter.
    localparam int CNT_W = 4;

    // Reset-request conditioning states.
    typedef enum logic [1:0] {
        R_IDLE   = 2'd0,
        R_QUAL   = 2'd1,
        R_ACTIVE = 2'd2,
        R_HOLD   = 2'd3
    } res_state_t;

endpackage

// File: rtl/irq_pin_conditioner_pin_sync.sv
// Multi-stage synchroniser for one raw, active-low CPU pin.
// Resets to 1 so a pin looks inactive until real samples arrive.
module pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    output logic sync
);

    logic [SYNC_STAGES-1:0] sr;

    // Shift the raw pin through SYNC_STAGES flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr <= '1;
        end else begin
            sr <= {sr[SYNC_STAGES-2:0], pin};
        end
    end

    assign sync = sr[SYNC_STAGES-1];

endmodule

// File: rtl/irq_pin_conditioner.sv
// Conditions the raw RESB/NMIB/IRQB pins for the interrupt-priority stage:
// synchronises them, qualifies and stretches reset, latches NMI on its
// falling edge until acknowledged, and masks IRQ with the I flag.
// Optional build macro: IRQ_GLITCH_FILTER_EN (IRQ must stay low FILT_CYC cycles).
//
// NMI handshake: nmib_out low means a request is pending; the core answers
// with a single-cycle nmi_ack pulse when the vector fetch starts, which clears
// the request on the next edge unless a new falling edge arrives in that same
// cycle (the new edge wins). An ack with no request pending is ignored.
module irq_pin_conditioner
    import irq_cond_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int RES_MIN_CYC  = 2,
    parameter int RES_HOLD_CYC = 4,
    parameter int FILT_CYC     = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       resb_pin,
    input  logic       nmib_pin,
    input  logic       irqb_pin,
    input  logic       i_flag,
    input  logic       nmi_ack,
    output logic       resb_out,
    output logic       nmib_out,
    output logic       irqb_out,
    output res_state_t dbg_res_state
);

    localparam logic [CNT_W-1:0] MIN_LAST  = CNT_W'(RES_MIN_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(RES_HOLD_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic rs, ns, is;
    logic ns_prev, nmi_lat, irq_qual, irq_req;
    res_state_t state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic resb_nxt;

    pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_res (
        .clk(clk), .reset_n(reset_n), .pin(resb_pin), .sync(rs));
    pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_nmi (
        .clk(clk), .reset_n(reset_n), .pin(nmib_pin), .sync(ns));
    pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_irq (
        .clk(clk), .reset_n(reset_n), .pin(irqb_pin), .sync(is));

    // Reset FSM state, counter and registered reset output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= R_HOLD;
            cnt      <= HOLD_INIT;
            resb_out <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            resb_out <= resb_nxt;
        end
    end

    // Reset FSM next state: qualify a low run, then stretch the release.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            R_IDLE: begin
                if (!rs) begin
                    if (RES_MIN_CYC == 1) begin
                        state_nxt = R_ACTIVE;
                    end else begin
                        state_nxt = R_QUAL;
                        cnt_nxt   = CNT_ONE;
                    end
                end
            end
            R_QUAL: begin
                if (rs) begin
                    state_nxt = R_IDLE;
                end else if (cnt == MIN_LAST) begin
                    state_nxt = R_ACTIVE;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            R_ACTIVE: begin
                if (rs) begin
                    state_nxt = R_HOLD;
                    cnt_nxt   = HOLD_INIT;
                end
            end
            R_HOLD: begin
                if (!rs) begin
                    state_nxt = R_ACTIVE;
                end else if (cnt == CNT_ONE) begin
                    state_nxt = R_IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            default: begin
                state_nxt = R_HOLD;
                cnt_nxt   = HOLD_INIT;
            end
        endcase
    end

    // Reset output decode: asserted whenever the next state holds reset.
    always_comb begin
        resb_nxt = !((state_nxt == R_ACTIVE) || (state_nxt == R_HOLD));
    end

    assign dbg_res_state = state;

`ifdef IRQ_GLITCH_FILTER_EN
    logic [CNT_W-1:0] filt_cnt, filt_cnt_nxt;

    // IRQ filter count: consecutive low samples, saturating, cleared by any high.
    always_comb begin
        filt_cnt_nxt = filt_cnt;
        if (is) begin
            filt_cnt_nxt = '0;
        end else if (filt_cnt != '1) begin
            filt_cnt_nxt = filt_cnt + CNT_ONE;
        end
    end

    // IRQ filter counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt_nxt;
        end
    end

    assign irq_qual = !is && (filt_cnt_nxt >= CNT_W'(FILT_CYC));
`else
    assign irq_qual = !is;
`endif

    assign irq_req = irq_qual && !i_flag;

    // NMI edge latch and masked IRQ register; both suppressed while reset is out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ns_prev  <= 1'b1;
            nmi_lat  <= 1'b0;
            irqb_out <= 1'b1;
        end else begin
            ns_prev <= ns;
            if (!resb_out) begin
                nmi_lat <= 1'b0;
            end else if (ns_prev && !ns) begin
                nmi_lat <= 1'b1;
            end else if (nmi_ack) begin
                nmi_lat <= 1'b0;
            end
            irqb_out <= resb_out ? !irq_req : 1'b1;
        end
    end

    assign nmib_out = !nmi_lat;

endmodule

// File: tb/tb_irq_pin_conditioner.sv
// Self-checking bench for irq_pin_conditioner: directed sequences followed by
// random pin activity, compared cycle by cycle against a run-length model.
module tb_irq_pin_conditioner;
    import irq_cond_pkg::*;

    localparam int S    = 2;
    localparam int MIN  = 2;
    localparam int HOLD = 4;
    localparam int FILT = 3;

    logic clk, reset_n;
    logic resb_pin, nmib_pin, irqb_pin, i_flag, nmi_ack;
    logic resb_out, nmib_out, irqb_out;
    res_state_t dbg_res_state;

    int checks = 0;
    int failures = 0;

    logic [2:0] exp_q[$];
    bit hist_r[$];
    bit hist_n[$];
    bit hist_i[$];

    // Model state: edge index, output values and run lengths.
    int t = 0;
    bit m_resb = 1'b0;
    bit m_nmi = 1'b0;
    bit m_irqb = 1'b1;
    int low_run = 0;
    int high_run = 1;
    int irq_low_run = 0;

    irq_pin_conditioner #(
        .SYNC_STAGES(S), .RES_MIN_CYC(MIN), .RES_HOLD_CYC(HOLD), .FILT_CYC(FILT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .resb_pin(resb_pin), .nmib_pin(nmib_pin), .irqb_pin(irqb_pin),
        .i_flag(i_flag), .nmi_ack(nmi_ack),
        .resb_out(resb_out), .nmib_out(nmib_out), .irqb_out(irqb_out),
        .dbg_res_state(dbg_res_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pin value the conditioner acts on at edge tt: the pin sampled S edges
    // earlier; anything before release reads as the inactive level.
    function automatic bit obs(input int which, input int tt);
        int idx;
        idx = tt - S - 1;
        if (idx < 0) return 1'b1;
        case (which)
            0: return hist_r[idx];
            1: return hist_n[idx];
            default: return hist_i[idx];
        endcase
    endfunction

    // Behavioural reference for one clock edge.
    task automatic model_step(input bit r, input bit n, input bit i, input bit f, input bit a);
        bit rs, ns, ns_p, is_v, old_resb;
        t++;
        hist_r.push_back(r);
        hist_n.push_back(n);
        hist_i.push_back(i);
        rs = obs(0, t);
        ns = obs(1, t);
        ns_p = obs(1, t - 1);
        is_v = obs(2, t);
        old_resb = m_resb;
        // Reset: accept after MIN consecutive lows, release after HOLD+1 highs.
        if (!rs) begin
            if (low_run < 1000) low_run++;
            high_run = 0;
        end else begin
            if (high_run < 1000) high_run++;
            low_run = 0;
        end
        if (m_resb && low_run == MIN) m_resb = 1'b0;
        else if (!m_resb && high_run == HOLD + 1) m_resb = 1'b1;
        // NMI: falling edge of the synchronised pin sets, ack clears, reset forces off.
        if (!old_resb) m_nmi = 1'b0;
        else if (ns_p && !ns) m_nmi = 1'b1;
        else if (a) m_nmi = 1'b0;
        // IRQ: level, masked by the I flag.
        if (!is_v) begin
            if (irq_low_run < 15) irq_low_run++;
        end else begin
            irq_low_run = 0;
        end
        if (!old_resb) m_irqb = 1'b1;
`ifdef IRQ_GLITCH_FILTER_EN
        else m_irqb = !(!is_v && !f && irq_low_run >= FILT);
`else
        else m_irqb = !(!is_v && !f);
`endif
        exp_q.push_back({m_resb, !m_nmi, m_irqb});
    endtask

    // driver: apply inputs for the next edge, record expected outputs
    task automatic drive_cycle(input bit r, input bit n, input bit i, input bit f, input bit a);
        resb_pin = r;
        nmib_pin = n;
        irqb_pin = i;
        i_flag = f;
        nmi_ack = a;
        model_step(r, n, i, f, a);
        @(negedge clk);
    endtask

    task automatic idle(input int cyc, input bit n, input bit i, input bit f);
        for (int k = 0; k < cyc; k++) drive_cycle(1'b1, n, i, f, 1'b0);
    endtask

    // scoreboard monitor: one output word per clock edge
    initial begin
        logic [2:0] exp_v;
        logic [2:0] act_v;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                act_v = {resb_out, nmib_out, irqb_out};
                checks++;
                if (act_v !== exp_v) begin
                    failures++;
                    $display("FAIL out_cmp time=%0t {resb,nmib,irqb} got=%b expected=%b", $time, act_v, exp_v);
                end
            end
        end
    end

    // main sequence
    initial begin
        bit r, n, i, f, a;
        reset_n = 1'b0;
        resb_pin = 1'b1;
        nmib_pin = 1'b1;
        irqb_pin = 1'b1;
        i_flag = 1'b0;
        nmi_ack = 1'b0;

        // Reset values held for five cycles.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if ({resb_out, nmib_out, irqb_out} !== 3'b011) begin
                failures++;
                $display("FAIL reset_val cycle=%0d got=%b expected=011", k, {resb_out, nmib_out, irqb_out});
            end
        end
        reset_n = 1'b1;

        // Release stretch, then RESB glitch and a real reset pulse.
        idle(10, 1'b1, 1'b1, 1'b0);
        drive_cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(10, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 10; k++) drive_cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(12, 1'b1, 1'b1, 1'b0);

        // NMI fall and hold, ack at cycle 8, stay low, then re-arm.
        for (int k = 0; k < 14; k++) drive_cycle(1'b1, 1'b0, 1'b1, 1'b0, k == 8);
        idle(3, 1'b1, 1'b1, 1'b0);
        idle(6, 1'b0, 1'b1, 1'b0);
        // Ack coincident with the detection of a new edge.
        idle(3, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) drive_cycle(1'b1, 1'b0, 1'b1, 1'b0, k == S);
        drive_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(3, 1'b0, 1'b1, 1'b0);
        // NMIB held low across a RESB pulse.
        idle(3, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(12, 1'b0, 1'b1, 1'b0);
        idle(4, 1'b1, 1'b1, 1'b0);

        // IRQ masking, unmasking and release.
        idle(8, 1'b1, 1'b0, 1'b1);
        idle(6, 1'b1, 1'b0, 1'b0);
        idle(6, 1'b1, 1'b1, 1'b0);
        // Short and longer IRQ pulses.
        idle(2, 1'b1, 1'b0, 1'b0);
        idle(6, 1'b1, 1'b1, 1'b0);
        idle(5, 1'b1, 1'b0, 1'b0);
        idle(8, 1'b1, 1'b1, 1'b0);

        // Random pin activity with occasional resets and acks.
        r = 1'b1; n = 1'b1; i = 1'b1; f = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 29) == 0) r = ~r;
            if (!r && $urandom_range(0, 3) == 0) r = 1'b1;
            if ($urandom_range(0, 5) == 0) n = ~n;
            if ($urandom_range(0, 4) == 0) i = ~i;
            if ($urandom_range(0, 9) == 0) f = ~f;
            a = (m_nmi && $urandom_range(0, 3) == 0) || ($urandom_range(0, 19) == 0);
            drive_cycle(r, n, i, f, a);
        end
        idle(12, 1'b1, 1'b1, 1'b0);

        // Drain the scoreboard within a bounded number of cycles.
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
